// File: rtl/conv_tile_engine.sv
`default_nettype none
// ============================================================================
// conv_tile_engine : tiled fixed-point convolution, one Tm x Tn MAC term/cycle
// Revision: 1.0
// ============================================================================
module conv_tile_engine #(
  parameter int N_p     = 4,
  parameter int M_p     = 4,
  parameter int K_p     = 2,
  parameter int R_p     = 4,
  parameter int C_p     = 4,
  parameter int S_p     = 1,
  parameter int Tn_p    = 2,
  parameter int Tm_p    = 2,
  parameter int W_p     = 16,
  parameter int FRAC_p  = 8,
  parameter int ACC_W_p = 40,
  localparam int IR     = (R_p-1)*S_p+K_p,
  localparam int IC     = (C_p-1)*S_p+K_p,
  localparam int NT     = N_p/Tn_p,
  localparam int MT     = M_p/Tm_p,
  localparam int FM_AW  = (NT*IR*IC > 1) ? $clog2(NT*IR*IC) : 1,
  localparam int WT_AW  = (MT*NT*K_p*K_p > 1) ? $clog2(MT*NT*K_p*K_p) : 1,
  localparam int OUT_AW = (MT*R_p*C_p > 1) ? $clog2(MT*R_p*C_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     start_i,
  input  logic                     relu_en_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [FM_AW-1:0]         fm_addr_o,
  input  logic [Tn_p*W_p-1:0]      fm_data_i,
  output logic [WT_AW-1:0]         wt_addr_o,
  input  logic [Tm_p*Tn_p*W_p-1:0] wt_data_i,
  output logic                     out_we_o,
  output logic [OUT_AW-1:0]        out_addr_o,
  output logic [Tm_p*W_p-1:0]      out_data_o
);
  if ((N_p % Tn_p) != 0) begin : g_chk_n
    $error("conv_tile_engine: N_p must be divisible by Tn_p");
  end
  if ((M_p % Tm_p) != 0) begin : g_chk_m
    $error("conv_tile_engine: M_p must be divisible by Tm_p");
  end

  localparam int TM_W  = (MT   > 1) ? $clog2(MT)   : 1;
  localparam int ROW_W = (R_p  > 1) ? $clog2(R_p)  : 1;
  localparam int COL_W = (C_p  > 1) ? $clog2(C_p)  : 1;
  localparam int TN_W  = (NT   > 1) ? $clog2(NT)   : 1;
  localparam int K_W   = (K_p  > 1) ? $clog2(K_p)  : 1;

  localparam logic [TM_W-1:0]  c_TM_MAX  = TM_W'(MT-1);
  localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(R_p-1);
  localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(C_p-1);
  localparam logic [TN_W-1:0]  c_TN_MAX  = TN_W'(NT-1);
  localparam logic [K_W-1:0]   c_K_MAX   = K_W'(K_p-1);

  localparam logic signed [ACC_W_p-1:0] c_SAT_MAX = {{(ACC_W_p-W_p+1){1'b0}}, {(W_p-1){1'b1}}};
  localparam logic signed [ACC_W_p-1:0] c_SAT_MIN = {{(ACC_W_p-W_p+1){1'b1}}, {(W_p-1){1'b0}}};

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_drain;
  logic             r_relu;
  logic [TM_W-1:0]  r_tm;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [TN_W-1:0]  r_tn;
  logic [K_W-1:0]   r_i;
  logic [K_W-1:0]   r_j;

  logic               r_v1, r_first1, r_last1;
  logic [OUT_AW-1:0]  r_oaddr1;
  logic               r_we;
  logic [OUT_AW-1:0]  r_out_addr;
  logic signed [ACC_W_p-1:0] r_acc [Tm_p];

  logic w_j_wrap, w_i_wrap, w_tn_wrap, w_col_wrap, w_row_wrap, w_last;
  logic w_first;
  logic [OUT_AW-1:0] w_out_addr;
  logic signed [2*W_p-1:0]   w_prod [Tm_p][Tn_p];
  logic signed [ACC_W_p-1:0] w_sum  [Tm_p];
  logic signed [ACC_W_p-1:0] w_sh   [Tm_p];
  logic [W_p-1:0]            w_lane [Tm_p];

  // Carry chain of the loop nest; w_last marks the final term of the job.
  assign w_j_wrap   = (r_j == c_K_MAX);
  assign w_i_wrap   = w_j_wrap   && (r_i   == c_K_MAX);
  assign w_tn_wrap  = w_i_wrap   && (r_tn  == c_TN_MAX);
  assign w_col_wrap = w_tn_wrap  && (r_col == c_COL_MAX);
  assign w_row_wrap = w_col_wrap && (r_row == c_ROW_MAX);
  assign w_last     = w_row_wrap && (r_tm  == c_TM_MAX);
  assign w_first    = (r_tn == '0) && (r_i == '0) && (r_j == '0);

  assign fm_addr_o  = FM_AW'((32'(r_tn)*IR + 32'(r_row)*S_p + 32'(r_i))*IC
                             + 32'(r_col)*S_p + 32'(r_j));
  assign wt_addr_o  = WT_AW'(((32'(r_tm)*NT + 32'(r_tn))*K_p + 32'(r_i))*K_p + 32'(r_j));
  assign w_out_addr = OUT_AW'((32'(r_tm)*R_p + 32'(r_row))*C_p + 32'(r_col));

  assign busy_o     = (r_state == c_RUN) || (r_state == c_DRAIN);
  assign done_o     = (r_state == c_DONE);
  assign out_we_o   = r_we;
  assign out_addr_o = r_out_addr;

  always_comb begin
    for (int m = 0; m < Tm_p; m++) begin
      w_sum[m] = '0;
      for (int t = 0; t < Tn_p; t++) begin
        w_prod[m][t] = (2*W_p)'($signed(fm_data_i[t*W_p +: W_p]))
                     * (2*W_p)'($signed(wt_data_i[(m*Tn_p+t)*W_p +: W_p]));
        w_sum[m] = w_sum[m] + ACC_W_p'(w_prod[m][t]);
      end
    end
  end

  always_comb begin
    for (int m = 0; m < Tm_p; m++) begin
      w_sh[m] = r_acc[m] >>> FRAC_p;
      if (w_sh[m] > c_SAT_MAX)
        w_lane[m] = {1'b0, {(W_p-1){1'b1}}};
      else if (w_sh[m] < c_SAT_MIN)
        w_lane[m] = {1'b1, {(W_p-1){1'b0}}};
      else
        w_lane[m] = w_sh[m][W_p-1:0];
      if (r_relu && w_lane[m][W_p-1])
        w_lane[m] = '0;
    end
  end

  for (genvar m = 0; m < Tm_p; m++) begin : g_lane
    assign out_data_o[m*W_p +: W_p] = w_lane[m];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state    <= c_IDLE;
      r_drain    <= 1'b0;
      r_relu     <= 1'b0;
      r_tm       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_tn       <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_v1       <= 1'b0;
      r_first1   <= 1'b0;
      r_last1    <= 1'b0;
      r_oaddr1   <= '0;
      r_we       <= 1'b0;
      r_out_addr <= '0;
      for (int m = 0; m < Tm_p; m++) r_acc[m] <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start_i) begin
            r_state <= c_RUN;
            r_relu  <= relu_en_i;
          end
        end
        c_RUN: begin
          r_j <= w_j_wrap ? '0 : r_j + 1'b1;
          if (w_j_wrap)   r_i   <= w_i_wrap   ? '0 : r_i   + 1'b1;
          if (w_i_wrap)   r_tn  <= w_tn_wrap  ? '0 : r_tn  + 1'b1;
          if (w_tn_wrap)  r_col <= w_col_wrap ? '0 : r_col + 1'b1;
          if (w_col_wrap) r_row <= w_row_wrap ? '0 : r_row + 1'b1;
          if (w_row_wrap) r_tm  <= w_last     ? '0 : r_tm  + 1'b1;
          if (w_last)     r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          r_drain <= ~r_drain;
          if (r_drain) r_state <= c_DONE;
        end
        default: r_state <= c_IDLE;
      endcase

      // Stage 1 tracks the term whose read data arrives next cycle.
      r_v1     <= (r_state == c_RUN);
      r_first1 <= w_first;
      r_last1  <= w_tn_wrap;
      r_oaddr1 <= w_out_addr;

      if (r_v1) begin
        for (int m = 0; m < Tm_p; m++)
          r_acc[m] <= r_first1 ? w_sum[m] : r_acc[m] + w_sum[m];
      end

      r_we <= r_v1 && r_last1;
      if (r_v1 && r_last1) r_out_addr <= r_oaddr1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_engine.sv
`default_nettype none
// ============================================================================
// tb_conv_tile_engine : directed + randomized self-checking bench
// Revision: 1.0
// ============================================================================
module tb_conv_tile_engine;
  localparam int N = 4, M = 4, K = 2, R = 4, C = 4, S = 1;
  localparam int TN = 2, TM = 2, W = 16, FRAC = 8, ACCW = 40;
  localparam int IR = (R-1)*S+K, IC = (C-1)*S+K;
  localparam int NT = N/TN, MT = M/TM;
  localparam int T = MT*R*C*NT*K*K;
  localparam int FM_DEPTH = NT*IR*IC, WT_DEPTH = MT*NT*K*K, OUT_DEPTH = MT*R*C;
  localparam int FM_AW = $clog2(FM_DEPTH), WT_AW = $clog2(WT_DEPTH), OUT_AW = $clog2(OUT_DEPTH);

  logic                 clk_i = 1'b0;
  logic                 reset_ni;
  logic                 start_i;
  logic                 relu_en_i;
  logic                 busy_o, done_o, out_we_o;
  logic [FM_AW-1:0]     fm_addr_o;
  logic [TN*W-1:0]      fm_data_i;
  logic [WT_AW-1:0]     wt_addr_o;
  logic [TM*TN*W-1:0]   wt_data_i;
  logic [OUT_AW-1:0]    out_addr_o;
  logic [TM*W-1:0]      out_data_o;

  conv_tile_engine #(
    .N_p(N), .M_p(M), .K_p(K), .R_p(R), .C_p(C), .S_p(S),
    .Tn_p(TN), .Tm_p(TM), .W_p(W), .FRAC_p(FRAC), .ACC_W_p(ACCW)
  ) u_dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .relu_en_i(relu_en_i),
    .busy_o(busy_o), .done_o(done_o),
    .fm_addr_o(fm_addr_o), .fm_data_i(fm_data_i),
    .wt_addr_o(wt_addr_o), .wt_data_i(wt_data_i),
    .out_we_o(out_we_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Logical tensors and the banked memory images built from them
  int             fm_l [N][IR][IC];
  int             wt_l [M][N][K][K];
  logic [TN*W-1:0]    fm_mem [FM_DEPTH];
  logic [TM*TN*W-1:0] wt_mem [WT_DEPTH];
  logic [W-1:0]   exp_out [OUT_DEPTH][TM];
  bit             written [OUT_DEPTH];
  int             wr_count;
  int             checks = 0;
  int             errors = 0;

  // Synchronous-read memories with one cycle of latency
  always @(posedge clk_i) begin
    fm_data_i <= fm_mem[fm_addr_o];
    wt_data_i <= wt_mem[wt_addr_o];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (out_we_o) begin
      check("wr_addr_range", 64'(out_addr_o < OUT_DEPTH), 64'd1);
      check($sformatf("wr_dup a%0d", out_addr_o), 64'(written[out_addr_o]), 64'd0);
      written[out_addr_o] = 1'b1;
      for (int m = 0; m < TM; m++)
        check($sformatf("wr_data a%0d l%0d", out_addr_o, m),
              64'(out_data_o[m*W +: W]), 64'(exp_out[out_addr_o][m]));
      wr_count++;
    end
  end

  task automatic fill_const(input int fv, input int wv);
    foreach (fm_l[a, b, c]) fm_l[a][b][c] = fv;
    foreach (wt_l[a, b, c, d]) wt_l[a][b][c][d] = wv;
  endtask

  task automatic fill_rand(input int span);
    foreach (fm_l[a, b, c]) fm_l[a][b][c] = int'($urandom_range(0, 2*span-1)) - span;
    foreach (wt_l[a, b, c, d]) wt_l[a][b][c][d] = int'($urandom_range(0, 2*span-1)) - span;
  endtask

  task automatic fill_addrpat();
    foreach (fm_l[a, b, c]) fm_l[a][b][c] = a*16 + b*4 + c;
    foreach (wt_l[a, b, c, d]) wt_l[a][b][c][d] = 0;
    wt_l[0][0][1][1] = 256;
  endtask

  // Map logical tensors onto banks and compute the reference output image
  task automatic prepare(input logic relu);
    logic [W-1:0] v16;
    longint acc, v;
    for (int tn = 0; tn < NT; tn++)
      for (int r = 0; r < IR; r++)
        for (int c = 0; c < IC; c++)
          for (int t = 0; t < TN; t++) begin
            v16 = W'(fm_l[tn*TN+t][r][c]);
            fm_mem[(tn*IR+r)*IC+c][t*W +: W] = v16;
          end
    for (int tm = 0; tm < MT; tm++)
      for (int tn = 0; tn < NT; tn++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            for (int m = 0; m < TM; m++)
              for (int t = 0; t < TN; t++) begin
                v16 = W'(wt_l[tm*TM+m][tn*TN+t][i][j]);
                wt_mem[((tm*NT+tn)*K+i)*K+j][(m*TN+t)*W +: W] = v16;
              end
    for (int oc = 0; oc < M; oc++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          acc = 0;
          for (int ic = 0; ic < N; ic++)
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                acc += longint'(fm_l[ic][r*S+i][c*S+j]) * longint'(wt_l[oc][ic][i][j]);
          v = acc >>> FRAC;
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
          if (relu && v < 0) v = 0;
          exp_out[((oc/TM)*R + r)*C + c][oc%TM] = W'(v);
        end
    foreach (written[a]) written[a] = 1'b0;
    wr_count = 0;
  endtask

  task automatic run_job(input logic relu, input bit pulses, input int abort_at);
    int wr_at_abort;
    wr_at_abort = 0;
    prepare(relu);
    @(negedge clk_i);
    start_i   = 1'b1;
    relu_en_i = relu;
    for (int k = 1; k <= T+3; k++) begin
      @(negedge clk_i);
      start_i   = pulses && (k == 5 || k == T+2);
      relu_en_i = 1'($urandom_range(0, 1));
      if (abort_at != 0) begin
        if (k == abort_at) begin
          reset_ni    = 1'b0;
          wr_at_abort = wr_count;
        end
        if (k == abort_at+1) reset_ni = 1'b1;
        if (k > abort_at) begin
          check("abort_busy", 64'(busy_o), 64'd0);
          check("abort_done", 64'(done_o), 64'd0);
          check("abort_we", 64'(out_we_o), 64'd0);
        end
      end else begin
        check($sformatf("busy c%0d", k), 64'(busy_o), 64'(k <= T+2));
        check($sformatf("done c%0d", k), 64'(done_o), 64'(k == T+3));
        if (k == T+2) begin
          check("last_we", 64'(out_we_o), 64'd1);
          check("last_addr", 64'(out_addr_o), 64'(OUT_DEPTH-1));
        end
      end
    end
    start_i = 1'b0;
    if (abort_at != 0)
      check("abort_no_more_writes", 64'(wr_count), 64'(wr_at_abort));
    else
      check("wr_count", 64'(wr_count), 64'(OUT_DEPTH));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset_ni  = 1'b0;
    start_i   = 1'b0;
    relu_en_i = 1'b0;
    fill_const(0, 0);
    prepare(1'b0);
    repeat (3) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_we", 64'(out_we_o), 64'd0);
    check("rst_fm_addr", 64'(fm_addr_o), 64'd0);
    check("rst_wt_addr", 64'(wt_addr_o), 64'd0);
    check("rst_out_addr", 64'(out_addr_o), 64'd0);
    check("rst_out_data", 64'(out_data_o), 64'd0);
    reset_ni = 1'b1;

    // Unity data with stray start pulses, then an immediate back-to-back job
    fill_const(256, 256);      run_job(1'b0, 1'b1, 0);
    fill_rand(1024);           run_job(1'b1, 1'b0, 0);
    // Saturation in both directions
    fill_const(32767, 32767);  run_job(1'b0, 1'b0, 0);
    fill_const(-32768, 32767); run_job(1'b0, 1'b0, 0);
    // Negative results with and without ReLU
    fill_const(256, -256);     run_job(1'b1, 1'b0, 0);
    fill_const(256, -256);     run_job(1'b0, 1'b0, 0);
    // Address pattern with a single tap
    fill_addrpat();            run_job(1'b0, 1'b0, 0);
    // Randomized data
    fill_rand(1024);           run_job(1'b0, 1'b0, 0);
    fill_rand(32768);          run_job(1'b0, 1'b0, 0);
    fill_rand(512);            run_job(1'($urandom_range(0, 1)), 1'b0, 0);
    // Mid-job reset, then recovery
    fill_rand(1024);           run_job(1'b0, 1'b0, 100);
    repeat (2) @(negedge clk_i);
    fill_rand(1024);           run_job(1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
